// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display subsystem types and default clock-monitor constants
package display_pkg;

   localparam int unsigned DEF_WIN_CYCLES = 256;
   localparam int unsigned DEF_EXP_MIN    = 60;
   localparam int unsigned DEF_EXP_MAX    = 68;
   localparam int unsigned DEF_LOCK_WINS  = 4;
   localparam int unsigned DEF_LOSS_WINS  = 2;
   localparam int unsigned DEF_CW         = $clog2(DEF_WIN_CYCLES) + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } display_clk_mon_state_e;

endpackage

// File: rtl/display_clk_mon_if.sv
// rtl/display_clk_mon_if.sv - control and status bundle of the pixel clock monitor
interface display_clk_mon_if
   import display_pkg::*;
#(
   parameter int unsigned CW = DEF_CW
) ();

   logic          en;
   logic          pixel_clk;
   logic          clk_ok;
   logic [CW-1:0] meas_cnt;
   logic          meas_valid;
   logic          lost_irq;
   logic          pix_rst_req_n;

   modport master (
      input  en,
      input  pixel_clk,
      output clk_ok,
      output meas_cnt,
      output meas_valid,
      output lost_irq,
      output pix_rst_req_n
   );

   modport slave (
      output en,
      output pixel_clk,
      input  clk_ok,
      input  meas_cnt,
      input  meas_valid,
      input  lost_irq,
      input  pix_rst_req_n
   );

endinterface

// File: rtl/display_sync2.sv
// rtl/display_sync2.sv - two-flop level synchronizer, async active-low reset to 0
module display_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/display_clk_mon.sv
// rtl/display_clk_mon.sv - counts pixel_clk edges per clk_sys window and tracks lock/loss
module display_clk_mon
   import display_pkg::*;
#(
   parameter int unsigned WIN_CYCLES = DEF_WIN_CYCLES,
   parameter int unsigned EXP_MIN    = DEF_EXP_MIN,
   parameter int unsigned EXP_MAX    = DEF_EXP_MAX,
   parameter int unsigned LOCK_WINS  = DEF_LOCK_WINS,
   parameter int unsigned LOSS_WINS  = DEF_LOSS_WINS
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   display_clk_mon_if.master  mon
);

   localparam int unsigned CW      = $clog2(WIN_CYCLES) + 1;
   localparam int unsigned WW      = $clog2(WIN_CYCLES);
   localparam int unsigned RUN_MAX = (LOCK_WINS > LOSS_WINS) ? LOCK_WINS : LOSS_WINS;
   localparam int unsigned RW      = $clog2(RUN_MAX + 1);

   localparam logic [CW-1:0] CNT_SAT  = '1;
   localparam logic [CW-1:0] CNT_MIN  = CW'(EXP_MIN);
   localparam logic [CW-1:0] CNT_MAX  = CW'(EXP_MAX);
   localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);
   localparam logic [RW-1:0] RUN_LOCK = RW'(LOCK_WINS);
   localparam logic [RW-1:0] RUN_LOSS = RW'(LOSS_WINS);

   display_clk_mon_state_e state;

   logic          pix_s2;
   logic          pix_s3;
   logic          pix_edge;
   logic [WW-1:0] win_cnt;
   logic [CW-1:0] edge_cnt;
   logic [CW-1:0] win_count;
   logic          win_end;
   logic          win_good;
   logic [RW-1:0] good_run;
   logic [RW-1:0] bad_run;
   logic [RW-1:0] good_inc;
   logic [RW-1:0] bad_inc;

   logic [CW-1:0] meas_cnt_q;
   logic          meas_valid_q;
   logic          clk_ok_q;
   logic          lost_irq_q;
   logic          pix_rst_n_q;

   // pixel_clk is only ever sampled as data; the third flop gives a one-cycle rising-edge strobe
   display_sync2 u_sync (
      .clk   (clk_sys),
      .rst_n (rst_n),
      .d     (mon.pixel_clk),
      .q     (pix_s2)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pix_s3 <= 1'b0;
      end else begin
         pix_s3 <= pix_s2;
      end
   end

   assign pix_edge = pix_s2 & ~pix_s3;
   assign win_end  = (state != ST_IDLE) && (win_cnt == WIN_LAST);
   assign good_inc = good_run + 1'b1;
   assign bad_inc  = bad_run + 1'b1;

   // Running count including this cycle's edge; on the last window cycle it is the result
   always_comb begin
      win_count = edge_cnt;
      if (pix_edge && (edge_cnt != CNT_SAT)) begin
         win_count = edge_cnt + 1'b1;
      end
   end

   assign win_good = (win_count >= CNT_MIN) && (win_count <= CNT_MAX);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else if (!mon.en || (state == ST_IDLE)) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else if (win_end) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else begin
         win_cnt  <= win_cnt + 1'b1;
         edge_cnt <= win_count;
      end
   end

   // Decisions land on the same edge that publishes meas_cnt, so status moves with meas_valid
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         good_run     <= '0;
         bad_run      <= '0;
         meas_cnt_q   <= '0;
         meas_valid_q <= 1'b0;
         clk_ok_q     <= 1'b0;
         lost_irq_q   <= 1'b0;
         pix_rst_n_q  <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;
         lost_irq_q   <= 1'b0;
         if (!mon.en) begin
            state       <= ST_IDLE;
            good_run    <= '0;
            bad_run     <= '0;
            clk_ok_q    <= 1'b0;
            pix_rst_n_q <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_ACQUIRE;
               end
               ST_ACQUIRE: begin
                  if (win_end) begin
                     if (!win_good) begin
                        good_run <= '0;
                     end else if (good_inc >= RUN_LOCK) begin
                        state       <= ST_LOCKED;
                        good_run    <= '0;
                        bad_run     <= '0;
                        clk_ok_q    <= 1'b1;
                        pix_rst_n_q <= 1'b1;
                     end else begin
                        good_run <= good_inc;
                     end
                  end
               end
               ST_LOCKED: begin
                  if (win_end) begin
                     if (win_good) begin
                        bad_run <= '0;
                     end else if (bad_inc >= RUN_LOSS) begin
                        state       <= ST_LOST;
                        bad_run     <= '0;
                        clk_ok_q    <= 1'b0;
                        pix_rst_n_q <= 1'b0;
                        lost_irq_q  <= 1'b1;
                     end else begin
                        bad_run <= bad_inc;
                     end
                  end
               end
               ST_LOST: begin
                  if (win_end && win_good) begin
                     state    <= ST_ACQUIRE;
                     good_run <= RW'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
            if (win_end) begin
               meas_cnt_q   <= win_count;
               meas_valid_q <= 1'b1;
            end
         end
      end
   end

   assign mon.meas_cnt      = meas_cnt_q;
   assign mon.meas_valid    = meas_valid_q;
   assign mon.clk_ok        = clk_ok_q;
   assign mon.lost_irq      = lost_irq_q;
   assign mon.pix_rst_req_n = pix_rst_n_q;

endmodule

// File: tb/tb_display_clk_mon.sv
// tb/tb_display_clk_mon.sv - directed self-checking bench for display_clk_mon
module tb_display_clk_mon;
   import display_pkg::*;

   logic clk_sys = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   bnd_cnt [12] = '{60, 68, 60, 59, 68, 60, 68, 69, 60, 68, 60, 68};

   display_clk_mon_if mon ();

   display_clk_mon dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .mon     (mon)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at the negedge of window position 0; n<0 drives clk_sys/4, else n pulses from position 20
   task automatic run_window(input int n, input int len);
      for (int p = 0; p < len; p++) begin
         if (n < 0) mon.pixel_clk = ~p[1];
         else       mon.pixel_clk = (p >= 20) && (p < 20 + 2 * n) && (p % 2 == 0);
         @(negedge clk_sys);
         if (p == 0) begin
            check("meas_valid_one_cycle", mon.meas_valid, 0);
            check("lost_irq_idle", mon.lost_irq, 0);
         end
      end
   endtask

   task automatic check_win(input string tag, input int cnt, input logic ok, input logic irq);
      check({tag, "_valid"}, mon.meas_valid, 1);
      check({tag, "_cnt"}, mon.meas_cnt, cnt);
      check({tag, "_clk_ok"}, mon.clk_ok, ok);
      check({tag, "_pix_rst_n"}, mon.pix_rst_req_n, ok);
      check({tag, "_lost_irq"}, mon.lost_irq, irq);
   endtask

   initial begin
      rst_n         = 1'b0;
      mon.en        = 1'b0;
      mon.pixel_clk = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_meas_cnt", mon.meas_cnt, 0);
      check("rst_meas_valid", mon.meas_valid, 0);
      check("rst_clk_ok", mon.clk_ok, 0);
      check("rst_lost_irq", mon.lost_irq, 0);
      check("rst_pix_rst_n", mon.pix_rst_req_n, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("idle_meas_valid", mon.meas_valid, 0);
      check("idle_state", dut.state, ST_IDLE);

      // Window count boundaries: 59 and 69 break a good run, 60 and 68 build one
      mon.en = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < 12; i++) begin
         run_window(bnd_cnt[i], 256);
         check_win($sformatf("bnd%0d", i), bnd_cnt[i], (i == 11), 1'b0);
      end
      check("bnd_locked", dut.state, ST_LOCKED);

      // Pixel clock stops while locked
      run_window(0, 256);
      check_win("stop1", 0, 1'b1, 1'b0);
      run_window(0, 256);
      check_win("stop2", 0, 1'b0, 1'b1);
      check("stop_state", dut.state, ST_LOST);

      // Restore clk_sys/4 from LOST
      run_window(-1, 256);
      check_win("restore1", 64, 1'b0, 1'b0);
      check("restore_state", dut.state, ST_ACQUIRE);
      run_window(-1, 256);
      check_win("restore2", 64, 1'b0, 1'b0);
      run_window(-1, 256);
      check_win("restore3", 64, 1'b0, 1'b0);
      run_window(-1, 256);
      check_win("restore4", 64, 1'b1, 1'b0);

      // One-cycle en drop while locked
      mon.en        = 1'b0;
      mon.pixel_clk = 1'b0;
      @(negedge clk_sys);
      check("endrop_clk_ok", mon.clk_ok, 0);
      check("endrop_pix_rst_n", mon.pix_rst_req_n, 0);
      check("endrop_state", dut.state, ST_IDLE);
      check("endrop_meas_cnt", mon.meas_cnt, 64);
      check("endrop_lost_irq", mon.lost_irq, 0);
      check("endrop_meas_valid", mon.meas_valid, 0);
      mon.en = 1'b1;
      @(negedge clk_sys);
      check("enback_lost_irq", mon.lost_irq, 0);

      // Fresh acquisition at clk_sys/4 locks on the 4th measurement
      for (int i = 0; i < 4; i++) begin
         run_window(-1, 256);
         check_win($sformatf("acq%0d", i), 64, (i == 3), 1'b0);
      end

      // Reset mid-window while locked
      run_window(-1, 100);
      rst_n         = 1'b0;
      mon.pixel_clk = 1'b0;
      #1;
      check("midrst_meas_cnt", mon.meas_cnt, 0);
      check("midrst_meas_valid", mon.meas_valid, 0);
      check("midrst_clk_ok", mon.clk_ok, 0);
      check("midrst_lost_irq", mon.lost_irq, 0);
      check("midrst_pix_rst_n", mon.pix_rst_req_n, 0);
      check("midrst_state", dut.state, ST_IDLE);
      @(negedge clk_sys);
      rst_n = 1'b1;
      @(negedge clk_sys);
      check("relrst_meas_valid", mon.meas_valid, 0);
      for (int i = 0; i < 4; i++) begin
         run_window(-1, 256);
         check_win($sformatf("relock%0d", i), 64, (i == 3), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
